sha2_digest_accum: RTL and testbench
====================================

// Module: sha2_digest_accum
// PURPOSE
//  Feed-forward / chaining-value accumulator for the SHA-2 family, parametrised for 32-bit (SHA-224/256) and 64-bit (SHA-384/512) words.
//  Holds H0..H7 across a multi-block message. After each compression, adds the round core's final a..h to H modulo 2^WORD_W.
//  Feeds H back to the core as the next block's initial state. Presents the (optionally truncated) digest with a valid/ready handshake to the HMAC controller.
// PARAMETERS
//  WORD_W     32  word width; 32 = SHA-224/256, 64 = SHA-384/512 (other values illegal, elaboration error)
//  BLK_CNT_W  16  width of accepted-block counter
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous, active-low reset
//  start         in   1          pulse: begin new message, load IV into H
//  trunc         in   1          sampled at start: 0 = SHA-256/512 IV, full digest; 1 = SHA-224/384 IV, truncated digest
//  blk_valid     in   1          core final a..h valid
//  blk_last      in   1          qualifies blk_valid: last block of message
//  blk_ready     out  1          accumulator accepts a block this cycle
//  state_in      in   8*WORD_W   {a,b,c,d,e,f,g,h}, a in MSBs
//  chain_out     out  8*WORD_W   {H0..H7}, initial state for the next block
//  digest        out  8*WORD_W   final digest, H0 in MSBs
//  digest_valid  out  1          digest available
//  digest_ready  in   1          consumer takes digest
//  blk_count     out  BLK_CNT_W  blocks accepted since start
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; H=IV(256/512); digest=0; digest_valid=0; blk_ready=0; blk_count=0; trunc_q=0.
//  FSM IDLE -> ACCUM on start; ACCUM -> DONE on accepted block with blk_last; DONE -> IDLE on digest_valid&&digest_ready.
//  start in any state (incl. ACCUM/DONE): abort current message; H<=IV(trunc); trunc_q<=trunc; blk_count<=0; digest_valid<=0; next state ACCUM.
//  blk_ready = (state==ACCUM) && !start; combinational from state and start. Accept = blk_valid && blk_ready.
//  On accept: Hi <= Hi + word_i, truncated to WORD_W (true mod 2^W, no subtract-all-ones); blk_count++ (wraps at 2^BLK_CNT_W).
//  Latency 1: chain_out reflects the updated H the cycle after accept. On a last-block accept, digest_valid rises that same cycle.
//  blk_valid outside ACCUM is ignored; H unchanged.
//  digest registered on last accept: trunc_q==0 -> {H0..H7}.
//    trunc_q==1, W=32 -> {H0..H6, 32'h0}; trunc_q==1, W=64 -> {H0..H5, 128'h0}.
//  digest_valid held high, digest stable, until digest_ready; then digest_valid<=0, digest keeps its value.
//  start and blk_valid in the same cycle: start wins; block not accepted.
//  rst low mid-message: full reset, in-flight block discarded.
// CONFIGURATION
//  SHA2_DIGEST_IV_LOAD_EN defined: adds ports iv_load (in, 1) and iv_in (in, 8*WORD_W).
//    start && iv_load loads H <= iv_in instead of the constant IV. Used for HMAC precomputed ipad/opad states.
//    blk_count <= 1 on that load; trunc still sampled.
//  Not defined: ports absent; H always loaded from constant IV tables.
// STRUCTURE
//  sha2_pkg: IV constants (IV224, IV256, IV384, IV512), FSM state enum {IDLE, ACCUM, DONE}, word-count localparam.
//  Sub-module sha2_iv_sel: combinational IV mux (WORD_W, trunc) -> 8*WORD_W. Everything else is inline.
// TESTING
//  W=32, start trunc=0, one block state_in=0, blk_last=1 -> digest=6a09e667_bb67ae85_..._5be0cd19, blk_count=1.
//  W=32, word a=95f61999, others 0, last -> H0=00000000 (wraps mod 2^32), H1..H7=IV.
//  W=32, two blocks of all-ones words -> chain_out after block 1 = IV-1 per word; digest = IV-2 per word.
//  W=64 trunc=1, one zero block -> digest={IV384 H0..H5,128'h0}; W=32 trunc=1 -> H7 field 0, H0=c1059ed8.
//  Hold digest_ready=0 for 5 cycles -> digest_valid stays 1, digest stable; start mid-ACCUM -> H=IV, blk_count=0, digest_valid=0.
//  IV_LOAD_EN: start+iv_load, iv_in=all 0x01 words, zero block, last -> digest all 0x01 words; rst low mid-block -> reset values.

Source files
------------

// File: rtl/sha2_pkg.sv
// sha2_pkg: SHA-2 initial hash values, accumulator FSM states and word count.
package sha2_pkg;
  localparam int NWORDS = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] IV384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                                    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [511:0] IV512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
endpackage

// File: rtl/sha2_iv_sel.sv
// sha2_iv_sel: selects the constant initial hash value for the word width and truncation mode.
module sha2_iv_sel import sha2_pkg::*; #(
  parameter int WORD_W = 32
) (
  input  logic                     trunc,
  output logic [NWORDS*WORD_W-1:0] iv
);
  generate
    if (WORD_W == 32) begin : g_w32
      assign iv = trunc ? IV224 : IV256;
    end else begin : g_w64
      assign iv = trunc ? IV384 : IV512;
    end
  endgenerate
endmodule

// File: rtl/sha2_digest_accum.sv
// sha2_digest_accum: SHA-2 chaining-value accumulator with digest handshake.
// Defining SHA2_DIGEST_IV_LOAD_EN adds iv_load/iv_in for loading precomputed HMAC states.
module sha2_digest_accum import sha2_pkg::*; #(
  parameter int WORD_W    = 32,
  parameter int BLK_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     trunc,
  input  logic                     blk_valid,
  input  logic                     blk_last,
  output logic                     blk_ready,
  input  logic [NWORDS*WORD_W-1:0] state_in,
  output logic [NWORDS*WORD_W-1:0] chain_out,
  output logic [NWORDS*WORD_W-1:0] digest,
  output logic                     digest_valid,
  input  logic                     digest_ready,
  output logic [BLK_CNT_W-1:0]     blk_count
`ifdef SHA2_DIGEST_IV_LOAD_EN
  ,
  input  logic                     iv_load,
  input  logic [NWORDS*WORD_W-1:0] iv_in
`endif
);
  localparam int W = NWORDS * WORD_W;
  localparam int KEEP = (WORD_W == 32) ? 7 : 6;
  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_digest_accum: WORD_W must be 32 or 64");
    end
  endgenerate
  state_t state;
  logic trunc_q;
  logic [NWORDS-1:0][WORD_W-1:0] h, words, h_sum, h_dig;
  logic [W-1:0] iv, load_h;
  logic load_one;
  // During reset the IV selector is forced to the untruncated table.
  sha2_iv_sel #(.WORD_W(WORD_W)) u_iv_sel (.trunc(rst & trunc), .iv(iv));
`ifdef SHA2_DIGEST_IV_LOAD_EN
  assign load_h   = iv_load ? iv_in : iv;
  assign load_one = iv_load;
`else
  assign load_h   = iv;
  assign load_one = 1'b0;
`endif
  assign words     = state_in;
  assign chain_out = h;
  assign blk_ready = (state == ACCUM) && !start;
  // Word 7 of the packed array is H0; truncation clears the low-order words.
  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      h_sum[i] = h[i] + words[i];
      h_dig[i] = (trunc_q && i < NWORDS - KEEP) ? '0 : h_sum[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      h            <= iv;
      digest       <= '0;
      digest_valid <= 1'b0;
      blk_count    <= '0;
      trunc_q      <= 1'b0;
    end else if (start) begin
      state        <= ACCUM;
      h            <= load_h;
      trunc_q      <= trunc;
      blk_count    <= BLK_CNT_W'(load_one);
      digest_valid <= 1'b0;
    end else if (blk_valid && blk_ready) begin
      h         <= h_sum;
      blk_count <= blk_count + 1'b1;
      if (blk_last) begin
        state        <= DONE;
        digest       <= h_dig;
        digest_valid <= 1'b1;
      end
    end else if (state == DONE && digest_ready) begin
      state        <= IDLE;
      digest_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sha2_digest_accum.sv
// tb_sha2_digest_accum: 32- and 64-bit accumulators driven in lockstep against a word-array model.
// Exercises the iv_load path too when SHA2_DIGEST_IV_LOAD_EN is defined.
module tb_sha2_digest_accum;
  localparam logic [255:0] T224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] T256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] T384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                                   64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [511:0] T512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                   64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  logic clk = 0, rst = 0, start = 0, trunc = 0, blk_valid = 0, blk_last = 0, digest_ready = 0, iv_load = 0;
  logic [255:0] s32 = '0, ivi32 = '0, chain32, dig32;
  logic [511:0] s64 = '0, ivi64 = '0, chain64, dig64;
  logic rdy32, rdy64, dv32, dv64;
  logic [15:0] cnt32, cnt64;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m32 [8];
  logic [63:0] m64 [8];
  int mode;
  bit mt, mdv;
  logic [15:0] mcnt;
  logic [255:0] md32;
  logic [511:0] md64;

  always #5 clk = ~clk;

  sha2_digest_accum #(.WORD_W(32), .BLK_CNT_W(16)) d32 (
    .clk(clk), .rst(rst), .start(start), .trunc(trunc), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ready(rdy32), .state_in(s32), .chain_out(chain32), .digest(dig32), .digest_valid(dv32),
    .digest_ready(digest_ready), .blk_count(cnt32)
`ifdef SHA2_DIGEST_IV_LOAD_EN
    , .iv_load(iv_load), .iv_in(ivi32)
`endif
  );
  sha2_digest_accum #(.WORD_W(64), .BLK_CNT_W(16)) d64 (
    .clk(clk), .rst(rst), .start(start), .trunc(trunc), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ready(rdy64), .state_in(s64), .chain_out(chain64), .digest(dig64), .digest_valid(dv64),
    .digest_ready(digest_ready), .blk_count(cnt64)
`ifdef SHA2_DIGEST_IV_LOAD_EN
    , .iv_load(iv_load), .iv_in(ivi64)
`endif
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] iv32(input bit t, input int i);
    logic [255:0] v;
    v = t ? T224 : T256;
    return v[255-32*i -: 32];
  endfunction
  function automatic logic [63:0] iv64(input bit t, input int i);
    logic [511:0] v;
    v = t ? T384 : T512;
    return v[511-64*i -: 64];
  endfunction
  // Hi sits at word position i counted from the MSB end; truncated modes drop trailing Hi.
  function automatic logic [255:0] pack32(input bit t);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = (t && i == 7) ? 32'h0 : m32[i];
    return r;
  endfunction
  function automatic logic [511:0] pack64(input bit t);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[511-64*i -: 64] = (t && i >= 6) ? 64'h0 : m64[i];
    return r;
  endfunction

  task automatic model_update();
    if (!rst) begin
      mode = 0; mt = 0; mdv = 0; mcnt = 0; md32 = '0; md64 = '0;
      for (int i = 0; i < 8; i++) begin m32[i] = iv32(0, i); m64[i] = iv64(0, i); end
    end else if (start) begin
      mode = 1; mt = trunc; mdv = 0; mcnt = iv_load ? 16'd1 : 16'd0;
      for (int i = 0; i < 8; i++) begin
        m32[i] = iv_load ? ivi32[255-32*i -: 32] : iv32(trunc, i);
        m64[i] = iv_load ? ivi64[511-64*i -: 64] : iv64(trunc, i);
      end
    end else if (mode == 1 && blk_valid) begin
      for (int i = 0; i < 8; i++) begin
        m32[i] = m32[i] + s32[255-32*i -: 32];
        m64[i] = m64[i] + s64[511-64*i -: 64];
      end
      mcnt = mcnt + 16'd1;
      if (blk_last) begin mode = 2; mdv = 1; md32 = pack32(mt); md64 = pack64(mt); end
    end else if (mode == 2 && digest_ready) begin
      mode = 0; mdv = 0;
    end
  endtask

  task automatic step();
    #1;
    chk("blk_ready32", rdy32, (mode == 1 && !start));
    chk("blk_ready64", rdy64, (mode == 1 && !start));
    model_update();
    @(posedge clk);
    @(negedge clk);
    chk("chain32", chain32, pack32(0));
    chk("chain64", chain64, pack64(0));
    chk("dv32", dv32, mdv);
    chk("dv64", dv64, mdv);
    chk("cnt32", cnt32, mcnt);
    chk("cnt64", cnt64, mcnt);
    chk("digest32", dig32, md32);
    chk("digest64", dig64, md64);
  endtask

  task automatic ctl(input bit st, input bit tr, input bit bv, input bit bl, input bit dr);
    start = st; trunc = tr; blk_valid = bv; blk_last = bl; digest_ready = dr;
    step();
    start = 0; blk_valid = 0; blk_last = 0;
  endtask

  initial begin
    @(negedge clk);
    rst = 0;
    step();
    chk("rst_chain_h0", chain32[255:224], 32'h6a09e667);
    chk("rst_digest", dig32, 256'h0);
    rst = 1;
    ctl(0, 0, 1, 1, 0);
    chk("idle_ignore_cnt", cnt32, 16'd0);
    s32 = '0; s64 = '0;
    ctl(1, 0, 0, 0, 0);
    ctl(0, 0, 1, 1, 0);
    chk("zero_blk_digest", dig32, T256);
    chk("zero_blk_cnt", cnt32, 16'd1);
    ctl(0, 0, 0, 0, 1);
    s32 = {32'h95f61999, 224'h0};
    ctl(1, 0, 0, 0, 0);
    ctl(0, 0, 1, 1, 1);
    chk("wrap_h0", chain32[255:224], 32'h0);
    ctl(0, 0, 0, 0, 1);
    s32 = '1; s64 = '1;
    ctl(1, 0, 0, 0, 0);
    ctl(0, 0, 1, 0, 0);
    chk("ones_chain_h0", chain32[255:224], 32'h6a09e666);
    ctl(0, 0, 1, 1, 0);
    chk("ones_digest_h0", dig32[255:224], 32'h6a09e665);
    chk("ones_cnt", cnt32, 16'd2);
    s32 = '0; s64 = '0;
    ctl(1, 1, 0, 0, 0);
    ctl(0, 0, 1, 1, 0);
    chk("t224_h0", dig32[255:224], 32'hc1059ed8);
    chk("t224_h7", dig32[31:0], 32'h0);
    chk("t384_h0", dig64[511:448], 64'hcbbb9d5dc1059ed8);
    chk("t384_tail", dig64[127:0], 128'h0);
    for (int k = 0; k < 5; k++) ctl(0, 0, 0, 0, 0);
    chk("held_dv", dv32, 1'b1);
    ctl(0, 0, 0, 0, 1);
    ctl(1, 0, 0, 0, 0);
    s32 = 256'h5; s64 = 512'h7;
    ctl(0, 0, 1, 0, 0);
    ctl(1, 0, 1, 1, 0);
    chk("restart_cnt", cnt32, 16'd0);
    chk("restart_chain", chain32, T256);
`ifdef SHA2_DIGEST_IV_LOAD_EN
    ivi32 = {32{8'h01}}; ivi64 = {64{8'h01}}; iv_load = 1; s32 = '0; s64 = '0;
    ctl(1, 0, 0, 0, 0);
    iv_load = 0;
    chk("ivload_cnt", cnt32, 16'd1);
    ctl(0, 0, 1, 1, 0);
    chk("ivload_digest", dig32, {32{8'h01}});
    ctl(1, 0, 0, 0, 0);
    rst = 0;
    ctl(0, 0, 1, 0, 0);
    rst = 1;
    chk("midrst_chain", chain32, T256);
`endif
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < 8; i++) s32[32*i +: 32] = $urandom();
      for (int i = 0; i < 16; i++) s64[32*i +: 32] = $urandom();
`ifdef SHA2_DIGEST_IV_LOAD_EN
      iv_load = $urandom_range(0, 1);
      for (int i = 0; i < 8; i++) ivi32[32*i +: 32] = $urandom();
      for (int i = 0; i < 16; i++) ivi64[32*i +: 32] = $urandom();
`endif
      ctl($urandom_range(0, 11) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3) == 0, $urandom_range(0, 1));
    end
    rst = 1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
